sb_reg_file: RTL

Parametrised successor of the team's multi-port register file. Adds a per-register busy scoreboard so that each read port issues only when its two source registers and its destination register are hazard-free. Sits between decode and the execution units of the OOO core: decode requests operands, execution units write results back. Register 0 is hardwired to zero and is never busy.

---
 rtl/sb_reg_file.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sb_reg_file.sv
// Multi-port register file with a per-register busy scoreboard gating operand issue.
// Define SB_REG_FILE_BYPASS_EN to let same-cycle writebacks clear source hazards and forward data.
module sb_reg_file #(
  parameter int  NUM_REG    = 8,
  parameter int  REG_BIT    = 16,
  parameter int  NUM_R_PORT = 2,
  parameter int  NUM_W_PORT = 2,
  localparam int RID        = $clog2(NUM_REG)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_R_PORT-1:0]         rd_addr_vld,
  output logic [NUM_R_PORT-1:0]         rd_addr_rdy,
  input  logic [NUM_R_PORT*RID-1:0]     rd_addr0,
  input  logic [NUM_R_PORT*RID-1:0]     rd_addr1,
  input  logic [NUM_R_PORT-1:0]         rd_dst_vld,
  input  logic [NUM_R_PORT*RID-1:0]     rd_dst,
  output logic [NUM_R_PORT-1:0]         rd_data_vld,
  input  logic [NUM_R_PORT-1:0]         rd_data_rdy,
  output logic [NUM_R_PORT*REG_BIT-1:0] rd_data0,
  output logic [NUM_R_PORT*REG_BIT-1:0] rd_data1,
  input  logic [NUM_W_PORT-1:0]         wr_vld,
  output logic [NUM_W_PORT-1:0]         wr_rdy,
  input  logic [NUM_W_PORT*RID-1:0]     wr_addr,
  input  logic [NUM_W_PORT*REG_BIT-1:0] wr_data,
  output logic [NUM_REG-1:0]            busy
);

  logic [REG_BIT-1:0] regs_q [NUM_REG];
  logic [REG_BIT-1:0] regs_d [NUM_REG];

  logic [NUM_REG-1:0] busy_q, busy_d, set_mask, clr_mask, src_clr;

  logic [NUM_R_PORT-1:0] full_q, full_d, dstv_q, dstv_d, held_q, held_d;
  logic [NUM_R_PORT-1:0] issue, accept;

  logic [NUM_R_PORT-1:0][RID-1:0]     a0_q, a0_d, a1_q, a1_d, dst_q, dst_d;
  logic [NUM_R_PORT-1:0][REG_BIT-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic [NUM_R_PORT-1:0][REG_BIT-1:0] live0, live1, out0, out1;

  // Highest port applied first so the lowest writing port ends up owning the data.
  always_comb begin
    clr_mask = '0;
    for (int r = 0; r < NUM_REG; r++) regs_d[r] = regs_q[r];
    for (int w = NUM_W_PORT - 1; w >= 0; w--) begin
      if (wr_vld[w] && wr_addr[w*RID +: RID] != '0) begin
        clr_mask[wr_addr[w*RID +: RID]] = 1'b1;
        regs_d[wr_addr[w*RID +: RID]]   = wr_data[w*REG_BIT +: REG_BIT];
      end
    end
  end

`ifdef SB_REG_FILE_BYPASS_EN
  assign src_clr = ~busy_q | clr_mask | NUM_REG'(1);
`else
  assign src_clr = ~busy_q | NUM_REG'(1);
`endif

  // Ports resolve in index order; an issuing lower port claims its destination.
  always_comb begin
    set_mask    = '0;
    rd_data_vld = '0;
    issue       = '0;
    for (int p = 0; p < NUM_R_PORT; p++) begin
      if (full_q[p] && src_clr[a0_q[p]] && src_clr[a1_q[p]] &&
          (!dstv_q[p] || dst_q[p] == '0 || !busy_q[dst_q[p]]) &&
          !set_mask[a0_q[p]] && !set_mask[a1_q[p]] && !set_mask[dst_q[p]])
        rd_data_vld[p] = 1'b1;
      issue[p] = rd_data_vld[p] & rd_data_rdy[p];
      if (issue[p] && dstv_q[p] && dst_q[p] != '0)
        set_mask[dst_q[p]] = 1'b1;
    end
  end

  // Set beats clear when an issue and a writeback hit the same register.
  assign busy_d      = ((busy_q & ~clr_mask) | set_mask) & ~NUM_REG'(1);
  assign rd_addr_rdy = ~full_q | issue;
  assign accept      = rd_addr_vld & rd_addr_rdy;
  assign wr_rdy      = '1;
  assign busy        = busy_q;

  for (genvar gi = 0; gi < NUM_R_PORT; gi++) begin : g_port
`ifdef SB_REG_FILE_BYPASS_EN
    assign live0[gi] = regs_d[a0_q[gi]];
    assign live1[gi] = regs_d[a1_q[gi]];
`else
    assign live0[gi] = regs_q[a0_q[gi]];
    assign live1[gi] = regs_q[a1_q[gi]];
`endif
    // Once presented and stalled by the consumer, operands stay frozen.
    assign out0[gi] = held_q[gi] ? hold0_q[gi] : live0[gi];
    assign out1[gi] = held_q[gi] ? hold1_q[gi] : live1[gi];

    assign rd_data0[gi*REG_BIT +: REG_BIT] = out0[gi];
    assign rd_data1[gi*REG_BIT +: REG_BIT] = out1[gi];

    assign held_d[gi]  = rd_data_vld[gi] & ~rd_data_rdy[gi];
    assign hold0_d[gi] = out0[gi];
    assign hold1_d[gi] = out1[gi];

    assign full_d[gi] = accept[gi] | (full_q[gi] & ~issue[gi]);
    assign a0_d[gi]   = accept[gi] ? rd_addr0[gi*RID +: RID] : a0_q[gi];
    assign a1_d[gi]   = accept[gi] ? rd_addr1[gi*RID +: RID] : a1_q[gi];
    assign dst_d[gi]  = accept[gi] ? rd_dst[gi*RID +: RID]   : dst_q[gi];
    assign dstv_d[gi] = accept[gi] ? rd_dst_vld[gi]          : dstv_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REG; r++) regs_q[r] <= '0;
      busy_q  <= '0;
      full_q  <= '0;
      dstv_q  <= '0;
      held_q  <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      dst_q   <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) regs_q[r] <= regs_d[r];
      busy_q  <= busy_d;
      full_q  <= full_d;
      dstv_q  <= dstv_d;
      held_q  <= held_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      dst_q   <= dst_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end

endmodule
